mem_stage_ctrl: RTL and testbench

- Memory stage of the 16-bit pipelined core; consumes the EX/MEM pipeline register outputs every cycle.
- Drives a variable-latency data memory through a req/ack handshake and stalls the front of the pipe while an access is outstanding.
- Selects the writeback value and registers it at the MEM/WB boundary.

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_wb_select.sv | 52 +++++
 rtl/mem_stage_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and constants for the memory stage controller.
//   state_e      : memory-stage FSM states
//   wb_sel_e     : writeback source select codes
//   MAX_WAIT_DEF : default number of unacknowledged cycles before a timeout
//   CNT_W        : width of the saturating wait counter
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int MAX_WAIT_DEF = 15;
    localparam int CNT_W        = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_PC   = 3'd0,
        SEL_IMM  = 3'd1,
        SEL_SLBI = 3'd2,
        SEL_CMP  = 3'd3,
        SEL_MEM  = 3'd4,
        SEL_ALU  = 3'd5
    } wb_sel_e;

endpackage

// File: rtl/mem_wb_select.sv
// -----------------------------------------------------------------------------
// mem_wb_select
// Pure priority mux choosing the writeback source for the memory stage.
// Ports:
//   jump_i, lbi_i, slbi_i, comp_i     : source flags, highest priority first
//   mem_read_i, mem_write_i           : memory controls (a write masks the read)
//   pc_add_i, imm_i, slbi_res_i,
//   cmp_i, mem_rdata_i, alu_i         : candidate 16-bit values
//   sel_o                             : chosen source code
//   wb_data_o                         : chosen 16-bit value
// -----------------------------------------------------------------------------
module mem_wb_select
    import mem_stage_pkg::*;
(
    input  logic        jump_i,
    input  logic        lbi_i,
    input  logic        slbi_i,
    input  logic        comp_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [15:0] pc_add_i,
    input  logic [15:0] imm_i,
    input  logic [15:0] slbi_res_i,
    input  logic [15:0] cmp_i,
    input  logic [15:0] mem_rdata_i,
    input  logic [15:0] alu_i,
    output wb_sel_e     sel_o,
    output logic [15:0] wb_data_o
);

    always_comb begin
        sel_o = SEL_ALU;
        if (jump_i)                          sel_o = SEL_PC;
        else if (lbi_i)                      sel_o = SEL_IMM;
        else if (slbi_i)                     sel_o = SEL_SLBI;
        else if (comp_i)                     sel_o = SEL_CMP;
        else if (mem_read_i && !mem_write_i) sel_o = SEL_MEM;
    end

    always_comb begin
        wb_data_o = alu_i;
        case (sel_o)
            SEL_PC:   wb_data_o = pc_add_i;
            SEL_IMM:  wb_data_o = imm_i;
            SEL_SLBI: wb_data_o = slbi_res_i;
            SEL_CMP:  wb_data_o = cmp_i;
            SEL_MEM:  wb_data_o = mem_rdata_i;
            default:  wb_data_o = alu_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Memory stage of the 16-bit core: drives the data memory req/ack handshake,
// stalls upstream while an access is outstanding, times out stuck requests and
// registers the MEM/WB result.
//
// Optional build macro: MEM_ALIGN_CHECK_EN -- odd-address memory ops issue no
// request, set err_out and retire as a bubble.
//
// Ports:
//   clk, rst (sync, active high)
//   EX/MEM data : pc_add_in, alu_out_in, read_data_2_in, slbi_result_in,
//                 compare_in, immediate_in, write_r_in
//   EX/MEM ctrl : LBI_in, SLBI_in, COMP_REG_in, REG_WRITE_in, MEM_WRITE_in,
//                 MEM_READ_in, JUMP_in, HALT_in
//   memory      : mem_req, mem_wr, mem_addr, mem_wdata (out), mem_ack,
//                 mem_rdata (in)
//   pipeline    : stall_out, wb_data_out, write_r_out, REG_WRITE_out,
//                 valid_out, halted_out, err_out
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | no outstanding request
// BUSY   | request outstanding for 1 or more cycles
// HALTED | halt retired; only bubbles until reset
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int MAX_WAIT = mem_stage_pkg::MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_add_in,
    input  logic [15:0] alu_out_in,
    input  logic [15:0] read_data_2_in,
    input  logic [15:0] slbi_result_in,
    input  logic [15:0] compare_in,
    input  logic [15:0] immediate_in,
    input  logic [2:0]  write_r_in,
    input  logic        LBI_in,
    input  logic        SLBI_in,
    input  logic        COMP_REG_in,
    input  logic        REG_WRITE_in,
    input  logic        MEM_WRITE_in,
    input  logic        MEM_READ_in,
    input  logic        JUMP_in,
    input  logic        HALT_in,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        stall_out,
    output logic [15:0] wb_data_out,
    output logic [2:0]  write_r_out,
    output logic        REG_WRITE_out,
    output logic        valid_out,
    output logic        halted_out,
    output logic        err_out
);
    import mem_stage_pkg::*;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        wb_data_q;
    logic [2:0]         write_r_q;
    logic               reg_write_q;
    logic               valid_q;
    logic               halted_q;
    logic               err_q;

    logic               mem_op;
    logic               misalign;
    logic               retire;
    wb_sel_e            wb_sel;
    logic [15:0]        wb_value;

    assign mem_op = MEM_READ_in | MEM_WRITE_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mem_op & alu_out_in[0];
`else
    assign misalign = 1'b0;
`endif

    // Request is gated by rst so it drops in the reset cycle itself.
    assign mem_req   = mem_op & ((state_q == IDLE) | (state_q == BUSY))
                       & ~err_q & ~misalign & ~rst;
    assign mem_wr    = MEM_WRITE_in;
    assign mem_addr  = alu_out_in;
    assign mem_wdata = read_data_2_in;
    assign stall_out = mem_req & ~mem_ack;

    mem_wb_select u_wb_sel (
        .jump_i      (JUMP_in),
        .lbi_i       (LBI_in),
        .slbi_i      (SLBI_in),
        .comp_i      (COMP_REG_in),
        .mem_read_i  (MEM_READ_in),
        .mem_write_i (MEM_WRITE_in),
        .pc_add_i    (pc_add_in),
        .imm_i       (immediate_in),
        .slbi_res_i  (slbi_result_in),
        .cmp_i       (compare_in),
        .mem_rdata_i (mem_rdata),
        .alu_i       (alu_out_in),
        .sel_o       (wb_sel),
        .wb_data_o   (wb_value)
    );

    // A memory op blocked by err/misalignment has mem_req low and so bubbles.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            IDLE:    retire = mem_op ? (mem_req & mem_ack) : 1'b1;
            BUSY:    retire = mem_ack;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wb_data_q   <= '0;
            write_r_q   <= '0;
            reg_write_q <= 1'b0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            valid_q     <= retire;
            reg_write_q <= retire & REG_WRITE_in;
            if (retire) begin
                wb_data_q <= wb_value;
                write_r_q <= write_r_in;
                if (HALT_in) halted_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (retire && HALT_in) begin
                        state_q <= HALTED;
                    end else if (misalign) begin
                        err_q <= 1'b1;
                    end else if (mem_req && !mem_ack) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state_q <= HALT_in ? HALTED : IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data is only captured in a cycle where the memory acknowledges.
    a_load_needs_ack: assert property (@(posedge clk) disable iff (rst)
        (retire && (wb_sel == SEL_MEM)) |-> mem_ack);

    assign wb_data_out   = wb_data_q;
    assign write_r_out   = write_r_q;
    assign REG_WRITE_out = reg_write_q;
    assign valid_out     = valid_q;
    assign halted_out    = halted_q;
    assign err_out       = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_add_in, alu_out_in, read_data_2_in, slbi_result_in;
    logic [15:0] compare_in, immediate_in, mem_rdata;
    logic [2:0]  write_r_in;
    logic        LBI_in, SLBI_in, COMP_REG_in, REG_WRITE_in;
    logic        MEM_WRITE_in, MEM_READ_in, JUMP_in, HALT_in, mem_ack;
    logic        mem_req, mem_wr, stall_out, REG_WRITE_out, valid_out;
    logic        halted_out, err_out;
    logic [15:0] mem_addr, mem_wdata, wb_data_out;
    logic [2:0]  write_r_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .pc_add_in(pc_add_in), .alu_out_in(alu_out_in),
        .read_data_2_in(read_data_2_in), .slbi_result_in(slbi_result_in),
        .compare_in(compare_in), .immediate_in(immediate_in),
        .write_r_in(write_r_in),
        .LBI_in(LBI_in), .SLBI_in(SLBI_in), .COMP_REG_in(COMP_REG_in),
        .REG_WRITE_in(REG_WRITE_in), .MEM_WRITE_in(MEM_WRITE_in),
        .MEM_READ_in(MEM_READ_in), .JUMP_in(JUMP_in), .HALT_in(HALT_in),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_out(stall_out), .wb_data_out(wb_data_out),
        .write_r_out(write_r_out), .REG_WRITE_out(REG_WRITE_out),
        .valid_out(valid_out), .halted_out(halted_out), .err_out(err_out)
    );

    typedef struct {
        string       name;
        logic        jump, lbi, slbi, comp, rd, wr, regw;
        logic [2:0]  wr_r;
        logic [15:0] alu, rd2, pc, imm, sl, cmp, rdata;
        logic        ack;
        logic        e_req, e_wr, e_stall, e_valid, e_regw;
        logic [15:0] e_wb;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        pc_add_in = 0; alu_out_in = 0; read_data_2_in = 0; slbi_result_in = 0;
        compare_in = 0; immediate_in = 0; mem_rdata = 0; write_r_in = 0;
        LBI_in = 0; SLBI_in = 0; COMP_REG_in = 0; REG_WRITE_in = 0;
        MEM_WRITE_in = 0; MEM_READ_in = 0; JUMP_in = 0; HALT_in = 0; mem_ack = 0;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        edge_sample();
        edge_sample();
        rst = 1'b0;
    endtask

    task automatic set_load(input logic [15:0] addr, input logic [2:0] r, input logic ack);
        clear_in();
        MEM_READ_in = 1; alu_out_in = addr; REG_WRITE_in = 1; write_r_in = r; mem_ack = ack;
    endtask

    task automatic set_add(input logic [15:0] val, input logic [2:0] r);
        clear_in();
        alu_out_in = val; REG_WRITE_in = 1; write_r_in = r;
    endtask

    initial begin
        logic [15:0] exp_wb;
        int          n_stall;
        logic        done;

        vecs[0]  = '{"add",      0,0,0,0,0,0,1, 3'd3, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0,0,0,1,1, 16'h1234};
        vecs[1]  = '{"store",    0,0,0,0,0,1,0, 3'd0, 16'h0010, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1,1,0,1,0, 16'h0010};
        vecs[2]  = '{"jmp_lbi",  1,1,0,0,0,0,1, 3'd7, 16'h0000, 16'h0000, 16'h0202, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 0, 0,0,0,1,1, 16'h0202};
        vecs[3]  = '{"lbi_slbi", 0,1,1,0,0,0,1, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0007, 16'hABCD, 16'h0000, 16'h0000, 0, 0,0,0,1,1, 16'h0007};
        vecs[4]  = '{"slbi_cmp", 0,0,1,1,0,0,1, 3'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hABCD, 16'h0001, 16'h0000, 0, 0,0,0,1,1, 16'hABCD};
        vecs[5]  = '{"cmp",      0,0,0,1,0,0,1, 3'd4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 0, 0,0,0,1,1, 16'h0001};
        vecs[6]  = '{"load0w",   0,0,0,0,1,0,1, 3'd5, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE, 1, 1,0,0,1,1, 16'hCAFE};
        vecs[7]  = '{"rd_wr",    0,0,0,0,1,1,0, 3'd0, 16'h0030, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h9999, 1, 1,1,0,1,0, 16'h0030};
        vecs[8]  = '{"cmp_rd",   0,0,0,1,1,0,1, 3'd6, 16'h0034, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'h1111, 1, 1,0,0,1,1, 16'h0042};
        vecs[9]  = '{"noregw",   0,0,0,0,0,0,0, 3'd0, 16'h0ABC, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0,0,0,1,0, 16'h0ABC};
        vecs[10] = '{"odd_load", 0,0,0,0,1,0,1, 3'd1, 16'h0061, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1357, 1, 1,0,0,1,1, 16'h1357};

        // reset with a load pending: no request, all registered outputs 0
        rst = 1'b1;
        set_load(16'h0040, 3'd1, 1'b0);
        #4;
        chk("rst_req", mem_req, 0);
        chk("rst_stall", stall_out, 0);
        edge_sample();
        edge_sample();
        chk("rst_valid", valid_out, 0);
        chk("rst_wb", wb_data_out, 0);
        chk("rst_wr_r", write_r_out, 0);
        chk("rst_regw", REG_WRITE_out, 0);
        chk("rst_halt", halted_out, 0);
        chk("rst_err", err_out, 0);
        rst = 1'b0;

        // single-cycle vectors
        for (int i = 0; i < 11; i++) begin
            clear_in();
            JUMP_in = vecs[i].jump; LBI_in = vecs[i].lbi; SLBI_in = vecs[i].slbi;
            COMP_REG_in = vecs[i].comp; MEM_READ_in = vecs[i].rd; MEM_WRITE_in = vecs[i].wr;
            REG_WRITE_in = vecs[i].regw; write_r_in = vecs[i].wr_r;
            alu_out_in = vecs[i].alu; read_data_2_in = vecs[i].rd2; pc_add_in = vecs[i].pc;
            immediate_in = vecs[i].imm; slbi_result_in = vecs[i].sl; compare_in = vecs[i].cmp;
            mem_rdata = vecs[i].rdata; mem_ack = vecs[i].ack;
            #4;
            chk({vecs[i].name, "_req"}, mem_req, vecs[i].e_req);
            chk({vecs[i].name, "_mwr"}, mem_wr, vecs[i].e_wr);
            chk({vecs[i].name, "_stall"}, stall_out, vecs[i].e_stall);
            chk({vecs[i].name, "_addr"}, mem_addr, vecs[i].alu);
            chk({vecs[i].name, "_wdata"}, mem_wdata, vecs[i].rd2);
            edge_sample();
            chk({vecs[i].name, "_valid"}, valid_out, vecs[i].e_valid);
            chk({vecs[i].name, "_regw"}, REG_WRITE_out, vecs[i].e_regw);
            chk({vecs[i].name, "_wb"}, wb_data_out, vecs[i].e_wb);
            chk({vecs[i].name, "_wr_r"}, write_r_out, vecs[i].wr_r);
        end
        exp_wb = 16'h1357;

        // load acknowledged after 3 wait cycles
        for (int c = 0; c < 4; c++) begin
            set_load(16'h0040, 3'd2, c == 3);
            mem_rdata = (c == 3) ? 16'hBEEF : 16'h0000;
            #4;
            chk("ld3_req", mem_req, 1);
            chk("ld3_addr", mem_addr, 16'h0040);
            chk("ld3_stall", stall_out, c < 3);
            edge_sample();
            if (c < 3) begin
                chk("ld3_bub_valid", valid_out, 0);
                chk("ld3_bub_regw", REG_WRITE_out, 0);
                chk("ld3_bub_wb", wb_data_out, exp_wb);
            end else begin
                chk("ld3_valid", valid_out, 1);
                chk("ld3_wb", wb_data_out, 16'hBEEF);
                chk("ld3_wr_r", write_r_out, 3'd2);
            end
        end
        exp_wb = 16'hBEEF;

        // timeout: entry cycle plus counter 1..4 -> 5 stall cycles, then err
        set_load(16'h0050, 3'd4, 1'b0);
        n_stall = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #4;
            if (stall_out) n_stall++;
            edge_sample();
            chk("to_bub_valid", valid_out, 0);
            chk("to_bub_wb", wb_data_out, exp_wb);
            if (err_out) done = 1'b1;
        end
        chk("to_reached", done, 1);
        chk("to_stalls", n_stall, 5);
        #4;
        chk("to_req_after", mem_req, 0);
        chk("to_stall_after", stall_out, 0);
        edge_sample();
        chk("to_memop_bubble", valid_out, 0);
        set_add(16'h0777, 3'd3);
        #4;
        edge_sample();
        chk("to_add_valid", valid_out, 1);
        chk("to_add_wb", wb_data_out, 16'h0777);
        chk("to_err_sticky", err_out, 1);

        // halt with a load: access completes first, then terminal
        do_reset();
        chk("rst2_err", err_out, 0);
        set_load(16'h0090, 3'd6, 1'b0);
        HALT_in = 1;
        #4;
        chk("hl_stall", stall_out, 1);
        edge_sample();
        chk("hl_bub_valid", valid_out, 0);
        chk("hl_bub_halt", halted_out, 0);
        mem_ack = 1; mem_rdata = 16'h7777;
        #4;
        chk("hl_ack_stall", stall_out, 0);
        edge_sample();
        chk("hl_valid", valid_out, 1);
        chk("hl_halted", halted_out, 1);
        chk("hl_wb", wb_data_out, 16'h7777);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) set_add(16'h0123, 3'd1);
            else set_load(16'h00A0, 3'd1, 1'b0);
            #4;
            chk("hd_req", mem_req, 0);
            chk("hd_stall", stall_out, 0);
            edge_sample();
            chk("hd_valid", valid_out, 0);
            chk("hd_halted", halted_out, 1);
            chk("hd_wb", wb_data_out, 16'h7777);
        end

        // reset while BUSY
        do_reset();
        set_add(16'h4444, 3'd5);
        #4;
        edge_sample();
        chk("rb_add_wb", wb_data_out, 16'h4444);
        set_load(16'h0080, 3'd3, 1'b0);
        #4;
        chk("rb_stall", stall_out, 1);
        edge_sample();
        rst = 1'b1;
        #4;
        chk("rb_req_in_rst", mem_req, 0);
        chk("rb_stall_in_rst", stall_out, 0);
        edge_sample();
        chk("rb_valid", valid_out, 0);
        chk("rb_wb", wb_data_out, 0);
        chk("rb_wr_r", write_r_out, 0);
        chk("rb_regw", REG_WRITE_out, 0);
        chk("rb_err", err_out, 0);
        chk("rb_halt", halted_out, 0);
        rst = 1'b0;
        set_add(16'h0005, 3'd2);
        #4;
        chk("rb_add_stall", stall_out, 0);
        edge_sample();
        chk("rb_add_valid", valid_out, 1);
        chk("rb_add_wb2", wb_data_out, 16'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
